alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end that sits directly upstream of the 4-bit alu and drives its A/B/opcode inputs.
- Accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the alu and registers the alu result and four flags.
- Returns the registered result and flags over a second valid/ready handshake.
- Keeps an accumulator holding the last result, so chained operations can use it as operand A.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
WIDTH, 4, operand and result width; matches the alu.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept a command.
cmd_a  in  WIDTH  operand A; ignored when cmd_use_acc=1.
cmd_b  in  WIDTH  operand B.
cmd_opcode  in  4  alu opcode; passed through without interpretation.
cmd_use_acc  in  1  1 = operand A comes from the accumulator.
alu_a  out  WIDTH  registered operand A to the alu.
alu_b  out  WIDTH  registered operand B to the alu.
alu_opcode  out  4  registered opcode to the alu.
alu_result  in  WIDTH  alu result (combinational from alu_a/alu_b/alu_opcode).
alu_carry, alu_zero, alu_negative, alu_overflow  in  1 each  alu flags.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts the response.
rsp_result  out  WIDTH  captured result.
rsp_flags  out  4  captured flags {overflow, negative, zero, carry}.
acc  out  WIDTH  accumulator, i.e. the last captured result.
fifo_count  out  clog2(DEPTH)+1  number of FIFO entries.
busy  out  1  high when state is not IDLE or fifo_count is not 0.

Behaviour:
Reset (asynchronous, on rst high):
- All outputs and registers go to 0; state goes to IDLE.
- FIFO contents and any pending response are discarded.
- Reset mid-operation aborts the command in flight; no response is produced for it.

FIFO:
- cmd_ready = (fifo_count < DEPTH), combinational from count only; no bypass, so cmd_ready is low when full even in a pop cycle.
- Push when cmd_valid && cmd_ready. Each entry stores {a, b, opcode, use_acc}.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves fifo_count unchanged.
- Pop happens only under the FSM conditions below.

FSM states: IDLE, EXEC, HOLD.
- IDLE: if fifo_count > 0, pop the head and load the issue registers, then go to EXEC.
  - alu_a <= use_acc ? acc : a; alu_b <= b; alu_opcode <= opcode.
  - Otherwise stay in IDLE; alu_* hold their last values.
- EXEC: the alu evaluates the issue registers for one full cycle. At the end of EXEC:
  - rsp_result <= alu_result; rsp_flags <= {alu_overflow, alu_negative, alu_zero, alu_carry}.
  - acc <= alu_result; rsp_valid <= 1; go to HOLD.
- HOLD: rsp_valid stays high; rsp_result and rsp_flags stay stable until the handshake.
  - On rsp_valid && rsp_ready with fifo_count > 0: rsp_valid <= 0, pop and load the issue registers (same rules as IDLE, using the updated acc), go to EXEC.
  - On rsp_valid && rsp_ready with FIFO empty: rsp_valid <= 0, go to IDLE.
  - With rsp_ready low: stay in HOLD.

Timing:
- Latency: command accepted at edge E0 with the FSM in IDLE and FIFO empty → issue registers loaded at E1 → rsp_valid high after E2.
- Peak throughput is one command per 2 cycles (EXEC plus the HOLD handshake cycle).
- The accumulator is always updated before the next pop, so cmd_use_acc chains see the previous result.

Other rules:
- acc is never cleared except by reset.
- The block does not special-case opcodes: undefined opcodes, divide-by-zero and shifts are the alu's concern, and their outputs are captured as-is.

Test Plan:
- Reset applied mid-EXEC with 2 entries queued → immediately rsp_valid=0, fifo_count=0, acc=0, alu_*=0, busy=0; no response appears afterwards.
- Single command ADD a=3 b=4 with rsp_ready=1 → alu_a=3, alu_b=4, alu_opcode=0000 one cycle after accept; rsp_valid two cycles after accept with rsp_result=7, rsp_flags=0000, acc=7.
- Chain: SUB a=5 b=5, then AND a=x b=0xC with use_acc=1 → first rsp_result=0 with zero flag set (rsp_flags=0010); second drives alu_a=0 and gives rsp_result=0.
- Chain: ADD a=3 b=4, then ADD b=2 with use_acc=1 → second drives alu_a=7 and gives rsp_result=9, acc=9.
- Backpressure: hold rsp_ready=0 and push DEPTH+1 commands → cmd_ready drops when fifo_count=4 (so 4 queued, 1 in HOLD); rsp_result stays stable. Then raise rsp_ready=1 → all 5 responses come out in order, one every 2 cycles, with no loss or duplication.
- Simultaneous push/pop: push while the HOLD handshake pops, FIFO non-full → fifo_count unchanged and ordering preserved.
- Undefined opcode 1110 with a=3 b=3 → alu_opcode=1110 is forwarded unchanged, and rsp_result/rsp_flags equal whatever the alu outputs during EXEC.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Command FIFO and issue/response sequencer in front of a 4-bit alu,
//            with an accumulator that can be chained as operand A.
// Revision : 1.0
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [3:0]               cmd_opcode,
    input  logic                     cmd_use_acc,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_opcode,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    input  logic                     alu_negative,
    input  logic                     alu_overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [3:0]               rsp_flags,
    output logic [WIDTH-1:0]         acc,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_mem_a   [DEPTH];
    logic [WIDTH-1:0]   r_mem_b   [DEPTH];
    logic [3:0]         r_mem_op  [DEPTH];
    logic               r_mem_acc [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [3:0]         r_alu_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_rsp_result;
    logic [3:0]         r_rsp_flags;
    logic               r_rsp_valid;

    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_rsp_done;
    logic w_fifo_nonempty;

    // No bypass: a full FIFO refuses a push even in the cycle it pops.
    assign cmd_ready       = (r_count < c_cnt_w'(DEPTH));
    assign w_fifo_nonempty = (r_count != '0);
    assign w_push          = cmd_valid && cmd_ready;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_done = 1'b1;
                    if (w_fifo_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i]   <= '0;
                r_mem_b[i]   <= '0;
                r_mem_op[i]  <= '0;
                r_mem_acc[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr]   <= cmd_a;
                r_mem_b[r_wr_ptr]   <= cmd_b;
                r_mem_op[r_wr_ptr]  <= cmd_opcode;
                r_mem_acc[r_wr_ptr] <= cmd_use_acc;
                r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue, capture and accumulator
    // ------------------------------------------------------------------------
    // r_acc is already updated by the time HOLD pops, so chains see the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_acc        <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= r_mem_acc[r_rd_ptr] ? r_acc : r_mem_a[r_rd_ptr];
                r_alu_b  <= r_mem_b[r_rd_ptr];
                r_alu_op <= r_mem_op[r_rd_ptr];
            end
            if (w_capture) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= {alu_overflow, alu_negative, alu_zero, alu_carry};
                r_acc        <= alu_result;
                r_rsp_valid  <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign acc        = r_acc;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_valid  = r_rsp_valid;
    assign fifo_count = r_count;
    assign busy       = (r_state != ST_IDLE) || w_fifo_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench for alu_cmd_sequencer with a small alu model.
// Revision : 1.0
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_and = 4'b0010;
    localparam logic [3:0] c_op_udf = 4'b1110;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_opcode;
    logic       cmd_use_acc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [3:0] acc;
    logic [2:0] fifo_count;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_opcode   (cmd_opcode),
        .cmd_use_acc  (cmd_use_acc),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .acc          (acc),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    // Reference alu: ADD, SUB (carry = borrow), AND; anything else gives a^b^1010 with C=V=1.
    logic [3:0] m_res;
    logic       m_c;
    logic       m_v;
    always_comb begin
        m_res = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_opcode)
            c_op_add: begin
                {m_c, m_res} = {1'b0, alu_a} + {1'b0, alu_b};
                m_v = (alu_a[3] == alu_b[3]) && (m_res[3] != alu_a[3]);
            end
            c_op_sub: begin
                m_res = alu_a - alu_b;
                m_c   = (alu_a < alu_b);
                m_v   = (alu_a[3] != alu_b[3]) && (m_res[3] != alu_a[3]);
            end
            c_op_and: m_res = alu_a & alu_b;
            default: begin
                m_res = alu_a ^ alu_b ^ 4'b1010;
                m_c   = 1'b1;
                m_v   = 1'b1;
            end
        endcase
    end
    assign alu_result   = m_res;
    assign alu_carry    = m_c;
    assign alu_overflow = m_v;
    assign alu_zero     = (m_res == 4'd0);
    assign alu_negative = m_res[3];

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op, input logic use_acc);
        int n;
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_opcode  = op;
        cmd_use_acc = use_acc;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        if (n >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int gap);
        gap = 0;
        while (rsp_valid !== 1'b1 && gap < 40) begin
            step(1);
            gap++;
        end
        if (rsp_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, gap);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || acc !== 4'd0 || alu_a !== 4'd0 ||
            alu_b !== 4'd0 || alu_opcode !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
            rsp_result !== 4'd0 || rsp_flags !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: rv=%b cnt=%0d acc=%h a=%h b=%h op=%h busy=%b rdy=%b res=%h fl=%b, required all 0 except rdy=1",
                     rsp_valid, fifo_count, acc, alu_a, alu_b, alu_opcode, busy, cmd_ready, rsp_result, rsp_flags);
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        push(4'd3, 4'd4, c_op_add, 1'b0);
        step(1);
        n_tests++;
        if (alu_a !== 4'd3 || alu_b !== 4'd4 || alu_opcode !== c_op_add || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_issue: a=%h b=%h op=%b rv=%b, required 3 4 0000 0", alu_a, alu_b, alu_opcode, rsp_valid);
        end
        step(1);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'd7 || rsp_flags !== 4'b0000 || acc !== 4'd7) begin
            n_fail++;
            $display("FAIL single_rsp: rv=%b res=%h fl=%b acc=%h, required 1 7 0000 7", rsp_valid, rsp_result, rsp_flags, acc);
        end
        step(1);
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: rv=%b busy=%b, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_chain_zero();
        int gap;
        rsp_ready = 1'b1;
        push(4'd5, 4'd5, c_op_sub, 1'b0);
        push(4'hF, 4'hC, c_op_and, 1'b1);
        wait_rsp(gap);
        n_tests++;
        if (alu_a !== 4'd5 || rsp_result !== 4'd0 || rsp_flags !== 4'b0010) begin
            n_fail++;
            $display("FAIL chain_zero_sub: a=%h res=%h fl=%b, required 5 0 0010", alu_a, rsp_result, rsp_flags);
        end
        step(1);
        wait_rsp(gap);
        n_tests++;
        if (alu_a !== 4'd0 || alu_b !== 4'hC || rsp_result !== 4'd0 || rsp_flags !== 4'b0010 || acc !== 4'd0) begin
            n_fail++;
            $display("FAIL chain_zero_and: a=%h b=%h res=%h fl=%b acc=%h, required 0 c 0 0010 0",
                     alu_a, alu_b, rsp_result, rsp_flags, acc);
        end
        step(1);
    endtask

    task automatic test_chain_add();
        int gap;
        rsp_ready = 1'b1;
        push(4'd3, 4'd4, c_op_add, 1'b0);
        push(4'hF, 4'd2, c_op_add, 1'b1);
        wait_rsp(gap);
        n_tests++;
        if (alu_a !== 4'd3 || rsp_result !== 4'd7 || rsp_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL chain_add_first: a=%h res=%h fl=%b, required 3 7 0000", alu_a, rsp_result, rsp_flags);
        end
        step(1);
        wait_rsp(gap);
        n_tests++;
        if (alu_a !== 4'd7 || rsp_result !== 4'd9 || rsp_flags !== 4'b1100 || acc !== 4'd9) begin
            n_fail++;
            $display("FAIL chain_add_second: a=%h res=%h fl=%b acc=%h, required 7 9 1100 9",
                     alu_a, rsp_result, rsp_flags, acc);
        end
        step(1);
    endtask

    task automatic test_backpressure();
        int gap;
        logic [3:0] k;
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            k = 4'(i);
            push(k, 4'd1, c_op_add, 1'b0);
        end
        n_tests++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 4'd2) begin
            n_fail++;
            $display("FAIL bp_full: cnt=%0d rdy=%b rv=%b res=%h, required 4 0 1 2", fifo_count, cmd_ready, rsp_valid, rsp_result);
        end
        step(3);
        n_tests++;
        if (fifo_count !== 3'd4 || rsp_valid !== 1'b1 || rsp_result !== 4'd2 || rsp_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_stable: cnt=%0d rv=%b res=%h fl=%b, required 4 1 2 0000", fifo_count, rsp_valid, rsp_result, rsp_flags);
        end
        rsp_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_rsp(gap);
            k = 4'(i);
            n_tests++;
            if (alu_a !== k || rsp_result !== k + 4'd1 || rsp_flags !== 4'b0000 || gap !== (i == 1 ? 0 : 1)) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: a=%h res=%h fl=%b gap=%0d, required %h %h 0000 %0d",
                         i, alu_a, rsp_result, rsp_flags, gap, k, k + 4'd1, (i == 1 ? 0 : 1));
            end
            step(1);
        end
        n_tests++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: busy=%b cnt=%0d rv=%b, required 0 0 0", busy, fifo_count, rsp_valid);
        end
    endtask

    task automatic test_push_pop();
        int gap;
        rsp_ready = 1'b0;
        push(4'd1, 4'd2, c_op_add, 1'b0);
        wait_rsp(gap);
        push(4'd2, 4'd2, c_op_add, 1'b0);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'd3 || fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL pp_hold: rv=%b res=%h cnt=%0d, required 1 3 1", rsp_valid, rsp_result, fifo_count);
        end
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_a       = 4'd3;
        cmd_b       = 4'd3;
        cmd_opcode  = c_op_add;
        cmd_use_acc = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd1 || rsp_valid !== 1'b0 || alu_a !== 4'd2) begin
            n_fail++;
            $display("FAIL pp_count: cnt=%0d rv=%b a=%h, required 1 0 2", fifo_count, rsp_valid, alu_a);
        end
        wait_rsp(gap);
        n_tests++;
        if (alu_a !== 4'd2 || rsp_result !== 4'd4) begin
            n_fail++;
            $display("FAIL pp_second: a=%h res=%h, required 2 4", alu_a, rsp_result);
        end
        step(1);
        wait_rsp(gap);
        n_tests++;
        if (alu_a !== 4'd3 || rsp_result !== 4'd6 || rsp_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL pp_third: a=%h res=%h fl=%b, required 3 6 0000", alu_a, rsp_result, rsp_flags);
        end
        step(1);
    endtask

    task automatic test_undefined_opcode();
        int gap;
        rsp_ready = 1'b1;
        push(4'd3, 4'd3, c_op_udf, 1'b0);
        step(1);
        n_tests++;
        if (alu_opcode !== c_op_udf || alu_a !== 4'd3 || alu_b !== 4'd3) begin
            n_fail++;
            $display("FAIL udf_issue: op=%b a=%h b=%h, required 1110 3 3", alu_opcode, alu_a, alu_b);
        end
        wait_rsp(gap);
        n_tests++;
        if (rsp_result !== 4'b1010 || rsp_flags !== 4'b1101 || acc !== 4'b1010) begin
            n_fail++;
            $display("FAIL udf_rsp: res=%b fl=%b acc=%b, required 1010 1101 1010", rsp_result, rsp_flags, acc);
        end
        step(1);
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        rsp_ready = 1'b1;
        push(4'd1, 4'd2, c_op_add, 1'b0);
        push(4'd3, 4'd4, c_op_add, 1'b0);
        push(4'd5, 4'd6, c_op_add, 1'b0);
        push(4'd7, 4'd1, c_op_add, 1'b0);
        n_tests++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd2 || busy !== 1'b1 || alu_a !== 4'd3) begin
            n_fail++;
            $display("FAIL rst_pre: rv=%b cnt=%0d busy=%b a=%h, required 0 2 1 3", rsp_valid, fifo_count, busy, alu_a);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || acc !== 4'd0 || alu_a !== 4'd0 ||
            alu_b !== 4'd0 || alu_opcode !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: rv=%b cnt=%0d acc=%h a=%h b=%h op=%h busy=%b, required all 0",
                     rsp_valid, fifo_count, acc, alu_a, alu_b, alu_opcode, busy);
        end
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (rsp_valid !== 1'b0 || fifo_count !== 3'd0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_no_rsp: activity after reset rv=%b cnt=%0d, required 0 0", rsp_valid, fifo_count);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_opcode  = '0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b0;
        #1;
        test_reset();
        step(2);
        #2 rst = 1'b0;
        step(1);
        test_single();
        test_chain_zero();
        test_chain_add();
        test_backpressure();
        test_push_pop();
        test_undefined_opcode();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
